loa_error_monitor: RTL and testbench
====================================

// Module: loa_error_monitor
// PURPOSE
//  Streaming quality checker for lower-part OR (LOA) approximate adders: consumes operand pairs,
//  computes the exact and the LOA-approximate sum, and accumulates error statistics over a run.
//  Sits downstream of the operand generator in the adder characterisation harness.
// PARAMETERS
//  N      4   operand width
//  K      0   approximate low bits (0..N); carry into bit K = A[K-1]&B[K-1] (0 when K=0)
//  CNT_W  16  width of sample/error counters and of i_NumSamples
//  ACC_W  32  width of absolute-error accumulator
// PORTS
//  i_Clk         in   1      clock, rising edge
//  i_Rst         in   1      synchronous reset, active-high
//  i_Start       in   1      pulse: begin run (clears stats), honoured in IDLE/DONE only
//  i_NumSamples  in   CNT_W  samples per run, latched on i_Start; 0 -> straight to DONE
//  i_Valid       in   1      operand pair valid
//  o_Ready       out  1      monitor accepts pair; transfer = i_Valid & o_Ready
//  i_A, i_B      in   N      operands
//  o_Busy        out  1      state is RUN or DRAIN
//  o_Done        out  1      level, high in DONE until next i_Start
//  o_SampleCnt   out  CNT_W  pairs processed
//  o_ErrCnt      out  CNT_W  pairs with exact != approx
//  o_AbsErrSum   out  ACC_W  sum |exact - approx|, saturating at all-ones
//  o_MaxAbsErr   out  N+1    max |exact - approx| seen
// BEHAVIOUR
//  - Reset: state IDLE; o_Ready=0, o_Busy=0, o_Done=0, all statistics 0.
//  - Exact = A+B, N+1 bits. Approx (N+1 bits): bits[K-1:0]=A|B; bits[N:K]=A[N-1:K]+B[N-1:K]+cin.
//  - Err = exact - approx, signed N+2 bits; |Err| fits N+1 bits.
//  - Pipeline: S1 registers exact/approx on transfer; S2 registers |Err| and updates stats.
//    Stats reflect a pair accepted at cycle t from cycle t+2. No backpressure inside pipeline.
//  - FSM: IDLE -i_Start-> RUN (NumSamples>0) or DONE (NumSamples=0).
//    RUN: o_Ready=1 while accepted < target; on final transfer -> DRAIN.
//    DRAIN: o_Ready=0; wait until S1,S2 empty -> DONE (o_Done set the cycle after last update).
//    DONE -i_Start-> as IDLE. i_Start in RUN/DRAIN ignored.
//  - i_Start clears stats and pipeline valids same cycle as state change.
//  - Counters saturate at all-ones (no wrap); AbsErrSum saturates independently.
//  - i_Rst mid-run: pipeline flushed, stats cleared, IDLE next cycle; in-flight pairs dropped.
//  - i_Valid while o_Ready=0: ignored, no state effect. Operands may change freely without valid.
// CONFIGURATION
//  LOA_MON_SQERR_EN defined: extra port o_SqErrSum out 2*ACC_W, sum Err^2 (saturating),
//    updated in S2 alongside o_AbsErrSum, cleared on reset/i_Start; latency unchanged.
//  Undefined: port and squarer absent; all other behaviour identical.
// STRUCTURE
//  Shared package loa_mon_pkg: FSM state encoding (IDLE, RUN, DRAIN, DONE), default widths,
//    saturating-add helper function.
//  Sub-module loa_approx_sum #(N,K): combinational LOA approximate sum (N+1 bits), instanced in S1.
// TESTING
//  N=4,K=2: A=3,B=1 -> exact 4, approx 3; after 1 sample ErrCnt=1, AbsErrSum=1, MaxAbsErr=1.
//  N=4,K=2: A=6,B=6 then A=15,B=15, NumSamples=2 -> errs -2,-1; AbsErrSum=3, MaxAbsErr=2, Done=1.
//  K=0, NumSamples=100 random pairs with random i_Valid gaps -> ErrCnt=0, SampleCnt=100, Done.
//  NumSamples=0 on i_Start -> DONE next cycle, o_Ready never high, stats 0.
//  i_Rst asserted in RUN after 5 transfers -> next cycle IDLE, all outputs 0; i_Start restarts clean.
//  CNT_W=4, NumSamples=15, all pairs erroneous -> ErrCnt=15; ACC_W=4 forces AbsErrSum saturate at 15.

Source files
------------

// File: rtl/loa_mon_pkg.sv
// loa_mon_pkg: shared types and helpers for the LOA error monitor.
// Holds the FSM state encoding, default widths and a wide saturating adder.
package loa_mon_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_K     = 0;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_ACC_W = 32;

  // Working width of the saturating adder; every statistic is zero-extended into it.
  localparam int SAT_W = 128;
  localparam logic [SAT_W-1:0] SAT_ONE = {{(SAT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_t;

  // Adds a and b, clamping the result to the all-ones value of a w-bit field.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                              input logic [SAT_W-1:0] b,
                                              input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({1'b0, SAT_ONE} << w) - {1'b0, SAT_ONE};
    if (sum > lim) begin
      sat_add = lim[SAT_W-1:0];
    end else begin
      sat_add = sum[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/loa_approx_sum.sv
// loa_approx_sum: combinational lower-part OR approximate adder.
// The low K bits are A|B; the upper N-K bits add normally with a carry-in
// taken from the AND of the top approximate bit pair (no carry when K=0).
module loa_approx_sum
  import loa_mon_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K
) (
  input  logic [N-1:0] i_A,
  input  logic [N-1:0] i_B,
  output logic [N:0]   o_Sum
);

  localparam logic [N:0] ONE_W   = {{N{1'b0}}, 1'b1};
  localparam logic [N:0] LO_MASK = (ONE_W << K) - ONE_W;

  logic         w_cin;
  logic [N-1:0] w_lo;
  logic [N-1:0] w_a_hi;
  logic [N-1:0] w_b_hi;
  logic [N:0]   w_hi_sum;

  generate
    if (K == 0) begin : g_no_cin
      assign w_cin = 1'b0;
    end else begin : g_cin
      assign w_cin = i_A[K-1] & i_B[K-1];
    end
  endgenerate

  // Split operands into OR-ed low part and exactly added high part, then recombine.
  always_comb begin
    w_lo     = (i_A | i_B) & LO_MASK[N-1:0];
    w_a_hi   = i_A >> K;
    w_b_hi   = i_B >> K;
    w_hi_sum = {1'b0, w_a_hi} + {1'b0, w_b_hi} + {{N{1'b0}}, w_cin};
    o_Sum    = (w_hi_sum << K) | {1'b0, w_lo};
  end

endmodule

// File: rtl/loa_error_monitor.sv
// loa_error_monitor: streaming error-statistics checker for LOA approximate adders.
// S1 captures exact and approximate sums of each accepted pair; S2 (the statistics
// registers) folds |exact - approx| into saturating counters two cycles after acceptance.
// Optional feature: define LOA_MON_SQERR_EN to add o_SqErrSum, a saturating sum of Err^2.
module loa_error_monitor
  import loa_mon_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int K     = DEF_K,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [CNT_W-1:0] i_NumSamples,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [N-1:0]     i_A,
  input  logic [N-1:0]     i_B,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [CNT_W-1:0] o_SampleCnt,
  output logic [CNT_W-1:0] o_ErrCnt,
  output logic [ACC_W-1:0] o_AbsErrSum,
  output logic [N:0]       o_MaxAbsErr
`ifdef LOA_MON_SQERR_EN
  ,
  output logic [2*ACC_W-1:0] o_SqErrSum
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [N:0]       ERR_ZERO = {(N+1){1'b0}};

  mon_state_t       r_state;
  mon_state_t       w_next_state;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_accepted;
  logic             w_xfer;
  logic             w_start_ok;
  logic             w_last;

  logic             r_s1_valid;
  logic [N:0]       r_s1_exact;
  logic [N:0]       r_s1_approx;
  logic [N:0]       w_exact;
  logic [N:0]       w_approx;
  logic [N:0]       w_abs;

  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [ACC_W-1:0] r_abs_sum;
  logic [N:0]       r_max_abs;

  assign w_exact    = {1'b0, i_A} + {1'b0, i_B};
  assign w_xfer     = i_Valid & o_Ready;
  assign w_start_ok = i_Start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_last     = w_xfer & (r_accepted == (r_target - CNT_ONE));

  loa_approx_sum #(
    .N (N),
    .K (K)
  ) u_approx (
    .i_A   (i_A),
    .i_B   (i_B),
    .o_Sum (w_approx)
  );

  // FSM state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; DRAIN ends once S1 is empty because S2 commits on capture.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_Start) begin
          if (i_NumSamples == CNT_ZERO) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_RUN;
          end
        end else begin
          w_next_state = r_state;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!r_s1_valid) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    o_Ready = 1'b0;
    o_Busy  = 1'b0;
    o_Done  = 1'b0;
    case (r_state)
      ST_IDLE:  o_Ready = 1'b0;
      ST_RUN: begin
        o_Ready = 1'b1;
        o_Busy  = 1'b1;
      end
      ST_DRAIN: o_Busy = 1'b1;
      ST_DONE:  o_Done = 1'b1;
      default:  o_Done = 1'b0;
    endcase
  end

  // Run target latched on start, acceptance counter stepped on every transfer.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_target   <= CNT_ZERO;
      r_accepted <= CNT_ZERO;
    end else if (w_start_ok) begin
      r_target   <= i_NumSamples;
      r_accepted <= CNT_ZERO;
    end else if (w_xfer) begin
      r_accepted <= r_accepted + CNT_ONE;
    end
  end

  // S1: capture exact and approximate sums of each accepted pair.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_exact  <= ERR_ZERO;
      r_s1_approx <= ERR_ZERO;
    end else if (w_start_ok) begin
      r_s1_valid  <= 1'b0;
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_exact  <= w_exact;
        r_s1_approx <= w_approx;
      end
    end
  end

  // Magnitude of the signed error, formed without a sign bit.
  always_comb begin
    if (r_s1_exact >= r_s1_approx) begin
      w_abs = r_s1_exact - r_s1_approx;
    end else begin
      w_abs = r_s1_approx - r_s1_exact;
    end
  end

  // S2: fold the S1 error into the saturating statistics.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || w_start_ok) begin
      r_sample_cnt <= CNT_ZERO;
      r_err_cnt    <= CNT_ZERO;
      r_abs_sum    <= {ACC_W{1'b0}};
      r_max_abs    <= ERR_ZERO;
    end else if (r_s1_valid) begin
      r_sample_cnt <= CNT_W'(sat_add(SAT_W'(r_sample_cnt), SAT_ONE, CNT_W));
      if (w_abs != ERR_ZERO) begin
        r_err_cnt <= CNT_W'(sat_add(SAT_W'(r_err_cnt), SAT_ONE, CNT_W));
      end
      r_abs_sum <= ACC_W'(sat_add(SAT_W'(r_abs_sum), SAT_W'(w_abs), ACC_W));
      if (w_abs > r_max_abs) begin
        r_max_abs <= w_abs;
      end
    end
  end

  assign o_SampleCnt = r_sample_cnt;
  assign o_ErrCnt    = r_err_cnt;
  assign o_AbsErrSum = r_abs_sum;
  assign o_MaxAbsErr = r_max_abs;

`ifdef LOA_MON_SQERR_EN
  logic [2*N+1:0]   w_sq;
  logic [2*ACC_W-1:0] r_sq_sum;

  assign w_sq = {{(N+1){1'b0}}, w_abs} * {{(N+1){1'b0}}, w_abs};

  // S2 companion: saturating sum of squared errors, same timing as the abs sum.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || w_start_ok) begin
      r_sq_sum <= {(2*ACC_W){1'b0}};
    end else if (r_s1_valid) begin
      r_sq_sum <= (2*ACC_W)'(sat_add(SAT_W'(r_sq_sum), SAT_W'(w_sq), 2*ACC_W));
    end
  end

  assign o_SqErrSum = r_sq_sum;
`endif

endmodule

// File: tb/tb_loa_error_monitor.sv
// tb_loa_error_monitor: randomized self-checking bench for loa_error_monitor.
// Three instances share operands: d0 (K=2), d1 (K=0) and d2 (K=2, 4-bit counters
// and accumulator, own start) so saturation is reachable. A behavioural model
// derives expected outputs from the adder arithmetic and the run protocol.
`timescale 1ns/1ps
module tb_loa_error_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_sh, start_sat, valid;
  logic [15:0] ns_sh;
  logic [3:0]  ns_sat;
  logic [3:0]  a, b;

  wire        rdy [3];
  wire        bsy [3];
  wire        dn  [3];
  wire [15:0] sc  [3];
  wire [15:0] ec  [3];
  wire [31:0] ab  [3];
  wire [4:0]  mx  [3];
  wire [3:0]  sc2, ec2, ab2;
  assign sc[2] = {12'd0, sc2};
  assign ec[2] = {12'd0, ec2};
  assign ab[2] = {28'd0, ab2};
`ifdef LOA_MON_SQERR_EN
  wire [63:0] sq0, sq1;
  wire [7:0]  sq2;
`endif

  loa_error_monitor #(.N(4), .K(2), .CNT_W(16), .ACC_W(32)) d0 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start_sh), .i_NumSamples(ns_sh), .i_Valid(valid),
    .o_Ready(rdy[0]), .i_A(a), .i_B(b), .o_Busy(bsy[0]), .o_Done(dn[0]),
    .o_SampleCnt(sc[0]), .o_ErrCnt(ec[0]), .o_AbsErrSum(ab[0]), .o_MaxAbsErr(mx[0])
`ifdef LOA_MON_SQERR_EN
    , .o_SqErrSum(sq0)
`endif
  );

  loa_error_monitor #(.N(4), .K(0), .CNT_W(16), .ACC_W(32)) d1 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start_sh), .i_NumSamples(ns_sh), .i_Valid(valid),
    .o_Ready(rdy[1]), .i_A(a), .i_B(b), .o_Busy(bsy[1]), .o_Done(dn[1]),
    .o_SampleCnt(sc[1]), .o_ErrCnt(ec[1]), .o_AbsErrSum(ab[1]), .o_MaxAbsErr(mx[1])
`ifdef LOA_MON_SQERR_EN
    , .o_SqErrSum(sq1)
`endif
  );

  loa_error_monitor #(.N(4), .K(2), .CNT_W(4), .ACC_W(4)) d2 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start_sat), .i_NumSamples(ns_sat), .i_Valid(valid),
    .o_Ready(rdy[2]), .i_A(a), .i_B(b), .o_Busy(bsy[2]), .o_Done(dn[2]),
    .o_SampleCnt(sc2), .o_ErrCnt(ec2), .o_AbsErrSum(ab2), .o_MaxAbsErr(mx[2])
`ifdef LOA_MON_SQERR_EN
    , .o_SqErrSum(sq2)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state, one slot per instance.
  longint m_samp [3], m_err [3], m_abs [3], m_sq [3];
  int     m_max  [3], m_left [3], m_drain [3];
  bit     m_ready [3], m_busy [3], m_done [3];
  bit     p_v [3];
  int     p_a [3], p_b [3];
  bit     last_xf [3];

  function automatic int kk(int d);  return (d == 1) ? 0 : 2;   endfunction
  function automatic int cw(int d);  return (d == 2) ? 4 : 16;  endfunction
  function automatic int aw(int d);  return (d == 2) ? 4 : 32;  endfunction

  // LOA sum from its definition: OR below bit k, true addition above with AND carry.
  function automatic int approx_of(int x, int y, int k);
    int lo, hi, cin;
    lo  = (x | y) % (1 << k);
    cin = (k > 0) ? (((x >> (k - 1)) & (y >> (k - 1))) & 1) : 0;
    hi  = (x >> k) + (y >> k) + cin;
    return hi * (1 << k) + lo;
  endfunction

  function automatic int abs_err(int x, int y, int k);
    int e;
    e = (x + y) - approx_of(x, y, k);
    return (e < 0) ? -e : e;
  endfunction

  task automatic apply(int d, int x, int y);
    int e;
    longint cmax, amax;
    e    = abs_err(x, y, kk(d));
    cmax = (longint'(1) << cw(d)) - 1;
    amax = (longint'(1) << aw(d)) - 1;
    m_samp[d] = (m_samp[d] + 1 > cmax) ? cmax : m_samp[d] + 1;
    if (e != 0) m_err[d] = (m_err[d] + 1 > cmax) ? cmax : m_err[d] + 1;
    m_abs[d] = (m_abs[d] + e > amax) ? amax : m_abs[d] + e;
    m_sq[d]  = m_sq[d] + e * e;
    if (e > m_max[d]) m_max[d] = e;
  endtask

  task automatic clear_stats(int d);
    m_samp[d] = 0; m_err[d] = 0; m_abs[d] = 0; m_sq[d] = 0; m_max[d] = 0;
    p_v[d] = 1'b0;
  endtask

  // One clock: derive transfers from the model, advance the model, sample 1ns later.
  task automatic tick();
    bit st [3];
    bit xf [3];
    int ns [3];
    st = '{start_sh, start_sh, start_sat};
    ns = '{int'(ns_sh), int'(ns_sh), int'(ns_sat)};
    for (int d = 0; d < 3; d++) xf[d] = valid && m_ready[d];
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      last_xf[d] = xf[d];
      if (rst) begin
        clear_stats(d);
        m_ready[d] = 0; m_busy[d] = 0; m_done[d] = 0; m_left[d] = 0; m_drain[d] = 0;
      end else begin
        if (p_v[d]) apply(d, p_a[d], p_b[d]);
        p_v[d] = xf[d]; p_a[d] = int'(a); p_b[d] = int'(b);
        if (st[d] && !m_busy[d]) begin
          clear_stats(d);
          m_left[d]  = ns[d];
          m_drain[d] = 0;
          m_done[d]  = (ns[d] == 0);
          m_busy[d]  = (ns[d] != 0);
          m_ready[d] = (ns[d] != 0);
        end else if (xf[d]) begin
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_ready[d] = 0;
            m_drain[d] = 2;
          end
        end else if (m_drain[d] > 0) begin
          m_drain[d]--;
          if (m_drain[d] == 0) begin
            m_busy[d] = 0;
            m_done[d] = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start_sh = 0; start_sat = 0; valid = 0; ns_sh = 16'd0; ns_sat = 4'd0;
    a = 4'd0; b = 4'd0;
    tick(); tick();
    rst = 0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({rdy[d], bsy[d], dn[d]} !== 3'b000) begin
        n_fail++; $display("FAIL reset_flags d%0d: got %b want 000", d, {rdy[d], bsy[d], dn[d]});
      end
      n_cmp++;
      if ({sc[d], ec[d], ab[d], mx[d]} !== 69'd0) begin
        n_fail++; $display("FAIL reset_stats d%0d: got sc=%0d ec=%0d ab=%0d mx=%0d want all 0",
                           d, sc[d], ec[d], ab[d], mx[d]);
      end
    end
  endtask

  task automatic test_directed_k2();
    // Single pair 3+1: exact 4, approx 3.
    ns_sh = 16'd1; start_sh = 1; tick(); start_sh = 0;
    a = 4'd3; b = 4'd1; valid = 1; tick(); valid = 0; a = 4'd9; b = 4'd9;
    n_cmp++;
    if (sc[0] !== 16'd0) begin
      n_fail++; $display("FAIL latency_t1: got SampleCnt=%0d want 0", sc[0]);
    end
    tick();
    n_cmp++;
    if ({sc[0], ec[0], ab[0], mx[0]} !== {16'd1, 16'd1, 32'd1, 5'd1}) begin
      n_fail++; $display("FAIL single_pair: got sc=%0d ec=%0d ab=%0d mx=%0d want 1 1 1 1",
                         sc[0], ec[0], ab[0], mx[0]);
    end
    tick();
    n_cmp++;
    if (dn[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got done=%b busy=%b want 1 0", dn[0], bsy[0]);
    end
    // Restart from DONE: 6+6 then 15+15, errors -2 and -1.
    ns_sh = 16'd2; start_sh = 1; tick(); start_sh = 0;
    a = 4'd6; b = 4'd6; valid = 1; tick();
    a = 4'd15; b = 4'd15; tick(); valid = 0;
    tick(); tick(); tick();
    n_cmp++;
    if ({sc[0], ec[0], ab[0], mx[0]} !== {16'd2, 16'd2, 32'd3, 5'd2}) begin
      n_fail++; $display("FAIL two_pair: got sc=%0d ec=%0d ab=%0d mx=%0d want 2 2 3 2",
                         sc[0], ec[0], ab[0], mx[0]);
    end
    n_cmp++;
    if (dn[0] !== 1'b1) begin
      n_fail++; $display("FAIL two_pair_done: got %b want 1", dn[0]);
    end
  endtask

  task automatic test_random_run();
    int cyc = 0;
    ns_sh = 16'd100; start_sh = 1; tick(); start_sh = 0;
    while (!m_done[0] && cyc < 2000) begin
      valid = ($urandom_range(0, 2) != 0);
      a = 4'($urandom); b = 4'($urandom);
      start_sh = (cyc == 20);
      ns_sh = 16'($urandom_range(0, 50));
      tick();
      cyc++;
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ({rdy[d], bsy[d], dn[d]} !== {m_ready[d], m_busy[d], m_done[d]}) begin
          n_fail++; $display("FAIL run_flags d%0d cyc %0d: got %b want %b", d, cyc,
                             {rdy[d], bsy[d], dn[d]}, {m_ready[d], m_busy[d], m_done[d]});
        end
        n_cmp++;
        if (sc[d] !== m_samp[d][15:0] || ec[d] !== m_err[d][15:0] || ab[d] !== m_abs[d][31:0]) begin
          n_fail++; $display("FAIL run_stats d%0d cyc %0d: got %0d/%0d/%0d want %0d/%0d/%0d", d, cyc,
                             sc[d], ec[d], ab[d], m_samp[d], m_err[d], m_abs[d]);
        end
      end
    end
    start_sh = 0; valid = 0;
    n_cmp++;
    if (!m_done[0]) begin
      n_fail++; $display("FAIL run_timeout: got %0d cycles want done before 2000", cyc);
    end
    n_cmp++;
    if ({sc[1], ec[1], dn[1]} !== {16'd100, 16'd0, 1'b1}) begin
      n_fail++; $display("FAIL k0_exact: got sc=%0d ec=%0d done=%b want 100 0 1", sc[1], ec[1], dn[1]);
    end
    n_cmp++;
    if (sc[0] !== 16'd100 || mx[0] !== m_max[0][4:0]) begin
      n_fail++; $display("FAIL k2_final: got sc=%0d mx=%0d want 100 %0d", sc[0], mx[0], m_max[0]);
    end
`ifdef LOA_MON_SQERR_EN
    n_cmp++;
    if (sq0 !== m_sq[0][63:0]) begin
      n_fail++; $display("FAIL sqerr: got %0d want %0d", sq0, m_sq[0]);
    end
`endif
  endtask

  task automatic test_zero_samples();
    ns_sh = 16'd0; start_sh = 1; tick(); start_sh = 0;
    n_cmp++;
    if ({rdy[0], bsy[0], dn[0]} !== 3'b001 || m_done[0] !== 1'b1) begin
      n_fail++; $display("FAIL zero_done: got %b want 001", {rdy[0], bsy[0], dn[0]});
    end
    valid = 1;
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom); b = 4'($urandom);
      tick();
      n_cmp++;
      if (rdy[0] !== 1'b0 || sc[0] !== 16'd0 || ab[0] !== 32'd0) begin
        n_fail++; $display("FAIL zero_idle: got rdy=%b sc=%0d ab=%0d want 0 0 0", rdy[0], sc[0], ab[0]);
      end
    end
    valid = 0;
  endtask

  task automatic test_reset_midrun();
    int cyc = 0;
    ns_sh = 16'd20; start_sh = 1; valid = 1; tick(); start_sh = 0;
    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom); b = 4'($urandom); tick();
    end
    n_cmp++;
    if (bsy[0] !== 1'b1 || m_left[0] !== 15) begin
      n_fail++; $display("FAIL midrun_busy: got busy=%b left=%0d want 1 15", bsy[0], m_left[0]);
    end
    rst = 1; valid = 0; tick(); rst = 0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({rdy[d], bsy[d], dn[d], sc[d], ec[d], ab[d], mx[d]} !== 72'd0) begin
        n_fail++; $display("FAIL midrun_rst d%0d: got rdy=%b sc=%0d ab=%0d want all 0", d, rdy[d], sc[d], ab[d]);
      end
    end
    tick(); tick();
    n_cmp++;
    if (sc[0] !== 16'd0) begin
      n_fail++; $display("FAIL midrun_flush: got SampleCnt=%0d want 0", sc[0]);
    end
    ns_sh = 16'd3; start_sh = 1; tick(); start_sh = 0;
    valid = 1;
    while (!m_done[0] && cyc < 50) begin
      a = 4'($urandom); b = 4'($urandom);
      if (m_ready[0] == 1'b0) valid = 0;
      tick(); cyc++;
    end
    valid = 0;
    n_cmp++;
    if ({sc[0], ab[0], mx[0], dn[0]} !== {16'd3, m_abs[0][31:0], m_max[0][4:0], 1'b1}) begin
      n_fail++; $display("FAIL restart: got sc=%0d ab=%0d mx=%0d done=%b want 3 %0d %0d 1",
                         sc[0], ab[0], mx[0], dn[0], m_abs[0], m_max[0]);
    end
  endtask

  task automatic test_saturate();
    int cyc = 0;
    ns_sat = 4'd15; start_sat = 1; tick(); start_sat = 0;
    a = 4'd6; b = 4'd6; valid = 1;
    while (m_left[2] > 0 && cyc < 200) begin
      tick(); cyc++;
      do begin
        a = 4'($urandom); b = 4'($urandom);
      end while (abs_err(int'(a), int'(b), 2) == 0);
    end
    valid = 0;
    tick(); tick(); tick();
    n_cmp++;
    if ({sc[2], ec[2], ab[2], dn[2]} !== {16'd15, 16'd15, 32'd15, 1'b1}) begin
      n_fail++; $display("FAIL saturate: got sc=%0d ec=%0d ab=%0d done=%b want 15 15 15 1",
                         sc[2], ec[2], ab[2], dn[2]);
    end
    n_cmp++;
    if (mx[2] !== m_max[2][4:0] || rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL saturate_max: got mx=%0d rdy0=%b want %0d 0", mx[2], rdy[0], m_max[2]);
    end
  endtask

  initial begin
    test_reset();
    test_directed_k2();
    test_random_run();
    test_zero_samples();
    test_reset_midrun();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
